// File: rtl/cnn_result_checker.sv
// cnn_result_checker: launches the CNN accelerator, waits for done (with an
// optional timeout), then sweeps the result BRAM against a golden ROM and
// reports pass/timeout, a saturating mismatch count and the first failing index.
//
// Optional build macro CHK_MASK_EN: adds i_cmp_mask. Only bits set in the mask
// take part in the compare. The mask is captured when go is accepted.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for go; results from the last run are held
// LAUNCH    | one-cycle start pulse to the accelerator
// WAIT_DONE | waiting for dut_done, timeout down-counter running
// SETTLE    | idle gap between done and the first read
// SWEEP     | one read per cycle on result and golden ports
// DRAIN     | reads stopped, last RD_LAT compares still in flight
// REPORT    | one-cycle chk_done, pass flag valid
module cnn_result_checker #(
  parameter int          DATA_W      = 32,
  parameter int          NUM_WORDS   = 294,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_STRIDE = 4,
  parameter int          RD_LAT      = 1,
  parameter int          SETTLE_CYC  = 2,
  parameter int          TIMEOUT_CYC = 1000000,
  parameter int          ERR_W       = 16,
  localparam int         IDX_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_go,
  output logic              o_busy,
  output logic              o_dut_start,
  input  logic              i_dut_done,
  output logic [31:0]       o_res_addr,
  output logic              o_res_en,
  output logic [3:0]        o_res_we,
  input  logic [DATA_W-1:0] i_res_dout,
  output logic [IDX_W-1:0]  o_gold_addr,
  output logic              o_gold_en,
  input  logic [DATA_W-1:0] i_gold_data,
  output logic              o_chk_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [ERR_W-1:0]  o_err_cnt,
  output logic [IDX_W-1:0]  o_first_err_idx
`ifdef CHK_MASK_EN
  ,
  input  logic [DATA_W-1:0] i_cmp_mask
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_DONE,
    ST_SETTLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_REPORT
  } state_t;

  // Timer reload values: each wait state runs its down-counter to zero.
  localparam bit              TO_EN       = (TIMEOUT_CYC != 0);
  localparam logic [31:0]     TO_LOAD     = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;
  localparam logic [31:0]     SETTLE_LOAD = (SETTLE_CYC > 0) ? 32'(SETTLE_CYC - 1) : 32'd0;
  localparam logic [31:0]     DRAIN_LOAD  = 32'(RD_LAT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_WORDS - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [31:0]         r_tmr;
  logic                w_tmr_load;
  logic [31:0]         w_tmr_val;
  logic                w_accept;
  logic                w_sweep;
  logic                w_to_hit;

  logic [IDX_W-1:0]    r_idx;
  logic [31:0]         r_res_addr;

  logic [RD_LAT-1:0]   r_vld;
  logic [IDX_W-1:0]    r_pidx [RD_LAT];
  logic                w_cmp_vld;
  logic [IDX_W-1:0]    w_cmp_idx;
  logic                w_mismatch;

  logic [ERR_W-1:0]    r_err_cnt;
  logic [IDX_W-1:0]    r_first_err_idx;
  logic                r_pass;
  logic                r_timeout;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode and the per-state control strobes.
  always_comb begin
    w_state_next = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_val    = 32'd0;
    w_accept     = 1'b0;
    w_sweep      = 1'b0;
    w_to_hit     = 1'b0;
    o_busy       = 1'b0;
    o_dut_start  = 1'b0;
    o_chk_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_go) begin
          w_accept     = 1'b1;
          w_state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        o_busy       = 1'b1;
        o_dut_start  = 1'b1;
        w_tmr_load   = 1'b1;
        w_tmr_val    = TO_LOAD;
        w_state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        o_busy = 1'b1;
        if (i_dut_done) begin
          w_tmr_load   = 1'b1;
          w_tmr_val    = SETTLE_LOAD;
          w_state_next = ST_SETTLE;
        end else if (TO_EN && (r_tmr == 32'd0)) begin
          w_to_hit     = 1'b1;
          w_state_next = ST_REPORT;
        end
      end
      ST_SETTLE: begin
        o_busy = 1'b1;
        if (r_tmr == 32'd0) w_state_next = ST_SWEEP;
      end
      ST_SWEEP: begin
        o_busy  = 1'b1;
        w_sweep = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_tmr_load   = 1'b1;
          w_tmr_val    = DRAIN_LOAD;
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        if (r_tmr == 32'd0) w_state_next = ST_REPORT;
      end
      ST_REPORT: begin
        o_busy       = 1'b1;
        o_chk_done   = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Shared wait timer: loaded on entry to a wait state, counts down to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst)                 r_tmr <= 32'd0;
    else if (w_tmr_load)       r_tmr <= w_tmr_val;
    else if (r_tmr != 32'd0)   r_tmr <= r_tmr - 32'd1;
  end

  // Read index and byte address; the address accumulates so no multiplier.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx      <= '0;
      r_res_addr <= 32'd0;
    end else if (w_accept) begin
      r_idx      <= '0;
      r_res_addr <= BASE_ADDR;
    end else if (w_sweep && (r_idx != LAST_IDX)) begin
      r_idx      <= r_idx + 1'b1;
      r_res_addr <= r_res_addr + 32'(ADDR_STRIDE);
    end
  end

  // Valid shift register tracking reads in flight through the memories.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_sweep;
      for (int k = 1; k < RD_LAT; k++) r_vld[k] <= r_vld[k-1];
    end
  end

  // Index shift register riding alongside the valid bits (data only, no reset).
  always_ff @(posedge i_clk) begin
    r_pidx[0] <= r_idx;
    for (int k = 1; k < RD_LAT; k++) r_pidx[k] <= r_pidx[k-1];
  end

  assign w_cmp_vld = r_vld[RD_LAT-1];
  assign w_cmp_idx = r_pidx[RD_LAT-1];

`ifdef CHK_MASK_EN
  logic [DATA_W-1:0] r_mask;

  // Compare mask is frozen for the whole run at go accept.
  always_ff @(posedge i_clk) begin
    if (i_rst)         r_mask <= '0;
    else if (w_accept) r_mask <= i_cmp_mask;
  end

  assign w_mismatch = w_cmp_vld && (((i_res_dout ^ i_gold_data) & r_mask) != '0);
`else
  assign w_mismatch = w_cmp_vld && (i_res_dout != i_gold_data);
`endif

  // Result registers: cleared at accept, updated by compares, held after REPORT.
  // pass is resolved on the DRAIN->REPORT edge so it already folds in the last
  // compare and is valid in the same cycle as chk_done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_cnt       <= '0;
      r_first_err_idx <= '0;
      r_pass          <= 1'b0;
      r_timeout       <= 1'b0;
    end else if (w_accept) begin
      r_err_cnt       <= '0;
      r_first_err_idx <= '0;
      r_pass          <= 1'b0;
      r_timeout       <= 1'b0;
    end else begin
      if (w_mismatch) begin
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        if (r_err_cnt == '0) r_first_err_idx <= w_cmp_idx;
      end
      if (w_to_hit) r_timeout <= 1'b1;
      if ((r_state == ST_DRAIN) && (w_state_next == ST_REPORT))
        r_pass <= (r_err_cnt == '0) && !w_mismatch;
    end
  end

  assign o_res_en        = w_sweep;
  assign o_gold_en       = w_sweep;
  assign o_res_we        = 4'b0000;
  assign o_res_addr      = r_res_addr;
  assign o_gold_addr     = r_idx;
  assign o_pass          = r_pass;
  assign o_timeout       = r_timeout;
  assign o_err_cnt       = r_err_cnt;
  assign o_first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_cnn_result_checker.sv
// Bench for cnn_result_checker: two instances (default build, and a variant
// with RD_LAT=3, BASE_ADDR=0x400, SETTLE_CYC=0, TIMEOUT_CYC=100, ERR_W=4)
// driven from a table of runs plus hand-written reset/go corner cases.
module tb_cnn_result_checker;

  localparam int N    = 294;
  localparam int TO_B = 100;

  typedef struct {
    int inst;
    int dly;
    int c0;
    int c1;
    bit all;
    bit go_mid;
    bit go_at_done;
    bit exp_pass;
    bit exp_to;
    int exp_err;
    int exp_first;
  } run_t;

  typedef struct {
    bit pass;
    bit to;
    int err;
    int first;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_go, a_done, b_go, b_done;
  logic        a_busy, a_start, a_res_en, a_gold_en, a_chk, a_pass, a_to;
  logic        b_busy, b_start, b_res_en, b_gold_en, b_chk, b_pass, b_to;
  logic [31:0] a_res_addr, b_res_addr;
  logic [3:0]  a_we, b_we;
  logic [31:0] a_res_dout, a_gold_data, b_res_dout, b_gold_data;
  logic [8:0]  a_gold_addr, b_gold_addr, a_first, b_first;
  logic [15:0] a_err;
  logic [3:0]  b_err;

  logic [31:0] gold_mem [N];
  logic [31:0] res_mem  [N];

  cnn_result_checker u_a (
    .i_clk(clk),
`ifdef CHK_MASK_EN
    .i_cmp_mask(32'hFFFF_FFFF),
`endif
    .i_rst(rst), .i_go(a_go), .o_busy(a_busy), .o_dut_start(a_start),
    .i_dut_done(a_done), .o_res_addr(a_res_addr), .o_res_en(a_res_en),
    .o_res_we(a_we), .i_res_dout(a_res_dout), .o_gold_addr(a_gold_addr),
    .o_gold_en(a_gold_en), .i_gold_data(a_gold_data), .o_chk_done(a_chk),
    .o_pass(a_pass), .o_timeout(a_to), .o_err_cnt(a_err),
    .o_first_err_idx(a_first)
  );

  cnn_result_checker #(
    .BASE_ADDR(32'h0000_0400), .RD_LAT(3), .SETTLE_CYC(0),
    .TIMEOUT_CYC(TO_B), .ERR_W(4)
  ) u_b (
    .i_clk(clk),
`ifdef CHK_MASK_EN
    .i_cmp_mask(32'hFFFF_FFFF),
`endif
    .i_rst(rst), .i_go(b_go), .o_busy(b_busy), .o_dut_start(b_start),
    .i_dut_done(b_done), .o_res_addr(b_res_addr), .o_res_en(b_res_en),
    .o_res_we(b_we), .i_res_dout(b_res_dout), .o_gold_addr(b_gold_addr),
    .o_gold_en(b_gold_en), .i_gold_data(b_gold_data), .o_chk_done(b_chk),
    .o_pass(b_pass), .o_timeout(b_to), .o_err_cnt(b_err),
    .o_first_err_idx(b_first)
  );

  // Memory models: out-of-range or idle reads return junk that never matches.
  function automatic logic [31:0] rd_res(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] d;
    d = addr - base;
    if (d[1:0] != 2'b00 || (d >> 2) >= 32'(N)) return 32'hDEAD_BEEF;
    return res_mem[d[10:2]];
  endfunction

  function automatic logic [31:0] rd_gold(input logic [8:0] idx);
    if (idx >= 9'(N)) return 32'hFEED_F00D;
    return gold_mem[idx];
  endfunction

  always @(posedge clk) begin
    a_res_dout  <= a_res_en  ? rd_res(a_res_addr, 32'h0) : 32'hBAD0_BAD0;
    a_gold_data <= a_gold_en ? rd_gold(a_gold_addr)       : 32'h0BAD_0BAD;
  end

  logic [31:0] b_rp [3];
  logic [31:0] b_gp [3];
  always @(posedge clk) begin
    b_rp[0] <= b_res_en  ? rd_res(b_res_addr, 32'h400) : 32'hBAD0_BAD0;
    b_gp[0] <= b_gold_en ? rd_gold(b_gold_addr)         : 32'h0BAD_0BAD;
    b_rp[1] <= b_rp[0];  b_rp[2] <= b_rp[1];
    b_gp[1] <= b_gp[0];  b_gp[2] <= b_gp[1];
  end
  assign b_res_dout  = b_rp[2];
  assign b_gold_data = b_gp[2];

  // Per-instance activity monitor, sampled on the falling edge.
  int   start_cnt [2] = '{0, 0};
  int   start_len [2] = '{0, 0};
  int   start_max [2] = '{0, 0};
  int   start_cyc [2] = '{0, 0};
  int   en_cnt    [2] = '{0, 0};
  int   first_en  [2] = '{0, 0};
  int   addr_bad  [2] = '{0, 0};
  int   done_cnt  [2] = '{0, 0};
  int   done_cyc  [2] = '{0, 0};
  logic prev_st   [2] = '{1'b0, 1'b0};

  task automatic mon(input int i, input logic st, input logic en, input logic gen,
                     input logic [31:0] addr, input logic [8:0] gaddr,
                     input logic [3:0] we, input logic chk_d);
    logic [31:0] base;
    base = (i == 1) ? 32'h400 : 32'h0;
    if (st) begin
      if (!prev_st[i]) begin
        start_cnt[i]++;
        start_cyc[i] = cyc;
        start_len[i] = 1;
        en_cnt[i]    = 0;
        addr_bad[i]  = 0;
        first_en[i]  = -1;
      end else begin
        start_len[i]++;
      end
      if (start_len[i] > start_max[i] || !prev_st[i]) start_max[i] = start_len[i];
    end
    prev_st[i] = st;
    if (en) begin
      if (addr !== base + 32'(en_cnt[i] * 4) || gaddr !== 9'(en_cnt[i]) ||
          we !== 4'b0000 || gen !== 1'b1) addr_bad[i]++;
      if (en_cnt[i] == 0) first_en[i] = cyc;
      en_cnt[i]++;
    end else if (gen) begin
      addr_bad[i]++;
    end
    if (chk_d) begin
      done_cnt[i]++;
      done_cyc[i] = cyc;
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_start, a_res_en, a_gold_en, a_res_addr, a_gold_addr, a_we, a_chk);
    mon(1, b_start, b_res_en, b_gold_en, b_res_addr, b_gold_addr, b_we, b_chk);
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q [$];
  run_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_go(input int sel, input logic v);
    if (sel == 1) b_go = v; else a_go = v;
  endtask

  task automatic set_done(input int sel, input logic v);
    if (sel == 1) b_done = v; else a_done = v;
  endtask

  task automatic run_vec(input run_t v);
    exp_t e;
    int   sel, s0, d0, k, drv_cyc, rdlat, gap;
    bit   got;
    sel   = v.inst;
    rdlat = (sel == 1) ? 3 : 1;
    gap   = (sel == 1) ? 2 : 3;
    for (int i = 0; i < N; i++) res_mem[i] = v.all ? ~gold_mem[i] : gold_mem[i];
    if (v.c0 >= 0) res_mem[v.c0] = gold_mem[v.c0] ^ 32'h0000_0100;
    if (v.c1 >= 0) res_mem[v.c1] = gold_mem[v.c1] ^ 32'h8000_0000;
    sb_q.push_back('{pass: v.exp_pass, to: v.exp_to, err: v.exp_err, first: v.exp_first});
    s0 = start_cnt[sel];
    d0 = done_cnt[sel];
    drv_cyc = -1;

    @(posedge clk); #1 set_go(sel, 1'b1);
    @(posedge clk); #1 set_go(sel, 1'b0);
    if (v.dly == 0) begin
      set_done(sel, 1'b1);
      @(posedge clk); #1 set_done(sel, 1'b0);
    end else if (v.dly > 0) begin
      repeat (v.dly) @(posedge clk);
      #1 set_done(sel, 1'b1);
      drv_cyc = cyc;
      @(posedge clk); #1 set_done(sel, 1'b0);
    end

    got = 1'b0;
    k   = 0;
    while (!got && k < 3000) begin
      @(negedge clk);
      if ((sel == 1) ? b_chk : a_chk) got = 1'b1;
      else begin
        @(posedge clk); #1 set_go(sel, v.go_mid && k == 100);
        k++;
      end
    end
    chk("chk_done_seen", 64'(got), 64'd1);
    e = sb_q.pop_front();
    chk("pass",      64'((sel == 1) ? b_pass : a_pass), 64'(e.pass));
    chk("timeout",   64'((sel == 1) ? b_to   : a_to),   64'(e.to));
    chk("err_cnt",   64'((sel == 1) ? 16'(b_err) : a_err), 64'(e.err));
    chk("first_err", 64'((sel == 1) ? b_first : a_first), 64'(e.first));

    if (v.go_at_done) begin
      set_go(sel, 1'b1);
      @(posedge clk); #1 set_go(sel, 1'b0);
    end
    repeat (5) @(negedge clk);

    chk("start_count",  64'(start_cnt[sel] - s0), 64'd1);
    chk("start_width",  64'(start_max[sel]), 64'd1);
    chk("chk_done_cnt", 64'(done_cnt[sel] - d0), 64'd1);
    chk("busy_after",   64'((sel == 1) ? b_busy : a_busy), 64'd0);
    chk("pass_hold",    64'((sel == 1) ? b_pass : a_pass), 64'(e.pass));
    chk("err_hold",     64'((sel == 1) ? 16'(b_err) : a_err), 64'(e.err));
    chk("read_count",   64'(en_cnt[sel]), e.to ? 64'd0 : 64'(N));
    chk("addr_seq",     64'(addr_bad[sel]), 64'd0);
    if (e.to) begin
      chk("timeout_lat", 64'(done_cyc[sel] - start_cyc[sel]), 64'(TO_B + 1));
    end else begin
      chk("sweep_lat", 64'(done_cyc[sel] - first_en[sel]), 64'(N + rdlat));
      if (drv_cyc >= 0) chk("settle_gap", 64'(first_en[sel] - drv_cyc), 64'(gap));
    end
  endtask

  task automatic reset_mid_sweep();
    int d0, k;
    bit seen;
    for (int i = 0; i < N; i++) res_mem[i] = gold_mem[i];
    d0 = done_cnt[0];
    @(posedge clk); #1 a_go = 1'b1;
    @(posedge clk); #1 a_go = 1'b0;
    repeat (10) @(posedge clk);
    #1 a_done = 1'b1;
    @(posedge clk); #1 a_done = 1'b0;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 100) begin
      @(negedge clk);
      if (a_res_en) seen = 1'b1;
      k++;
    end
    chk("rst_sweep_reached", 64'(seen), 64'd1);
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_ctrl", 64'({a_busy, a_start, a_res_en, a_we, a_gold_en, a_chk,
                              a_pass, a_to, a_err, a_first}), 64'd0);
    chk("rst_mid_addr", 64'({a_res_addr, a_gold_addr}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (400) @(negedge clk);
    chk("rst_no_chk_done", 64'(done_cnt[0] - d0), 64'd0);
    chk("rst_idle_busy",   64'(a_busy), 64'd0);
  endtask

  initial begin
    rst    = 1'b1;
    a_go   = 1'b0;
    b_go   = 1'b0;
    a_done = 1'b0;
    b_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      gold_mem[i] = ((32'(i) + 32'd1) * 32'h9E37_79B9) ^ (32'(i) << 7);
      res_mem[i]  = gold_mem[i];
    end

    //          inst dly  c0   c1  all mid atd pass to err first
    vecs[0] = '{0,   500, -1,  -1, 0,  0,  0,  1,   0, 0,  0};
    vecs[1] = '{0,   500, 5,   200,0,  0,  0,  0,   0, 2,  5};
    vecs[2] = '{0,   7,   0,   -1, 0,  0,  0,  0,   0, 1,  0};
    vecs[3] = '{1,   -1,  -1,  -1, 0,  0,  0,  0,   1, 0,  0};
    vecs[4] = '{1,   0,   -1,  -1, 0,  0,  0,  0,   1, 0,  0};
    vecs[5] = '{1,   20,  293, -1, 0,  0,  0,  0,   0, 1,  293};
    vecs[6] = '{1,   20,  -1,  -1, 1,  1,  0,  0,   0, 15, 0};
    vecs[7] = '{1,   20,  -1,  -1, 0,  0,  1,  1,   0, 0,  0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ctrl", 64'({a_busy, a_start, a_res_en, a_we, a_gold_en, a_chk,
                            a_pass, a_to, a_err, a_first}), 64'd0);
    chk("rst_a_addr", 64'({a_res_addr, a_gold_addr}), 64'd0);
    chk("rst_b_ctrl", 64'({b_busy, b_start, b_res_en, b_we, b_gold_en, b_chk,
                            b_pass, b_to, b_err, b_first}), 64'd0);
    chk("rst_b_addr", 64'({b_res_addr, b_gold_addr}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int v = 0; v < 8; v++) run_vec(vecs[v]);

    reset_mid_sweep();
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
